// File: rtl/button_pio_event_ctrl.sv
// Debounced push-button PIO with sticky press capture and a maskable level interrupt.
// Optional long-press capture is enabled by defining BUTTON_PIO_LONGPRESS_EN.
module button_pio_event_ctrl #(
  parameter int WIDTH           = 3,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 24'hFF_FFFF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] btn_state
);

  typedef enum logic {IDLE, COUNT} deb_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (WIDTH < 1 || WIDTH > 8 || DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_bad_param
    $error("button_pio_event_ctrl: parameter out of range");
  end

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '1;
      s    <= '1;
    end else begin
      meta <= in_port;
      s    <= meta;
    end
  end

  deb_state_t       state      [WIDTH];
  deb_state_t       state_next [WIDTH];
  logic [CNT_W-1:0] cnt        [WIDTH];
  logic [CNT_W-1:0] cnt_next   [WIDTH];
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] press;

  // Leaving IDLE already counts one stable cycle, so acceptance lands DEBOUNCE_CYCLES+2 clks after the pin.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_next[i] = state[i];
      cnt_next[i]   = cnt[i];
      accept[i]     = 1'b0;
      case (state[i])
        IDLE: begin
          cnt_next[i] = '0;
          if (s[i] != btn_state[i]) begin
            state_next[i] = COUNT;
            cnt_next[i]   = CNT_W'(1);
          end
        end
        COUNT: begin
          if (s[i] == btn_state[i]) begin
            state_next[i] = IDLE;
            cnt_next[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            accept[i]     = 1'b1;
            state_next[i] = IDLE;
            cnt_next[i]   = '0;
          end else begin
            cnt_next[i] = cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          state_next[i] = IDLE;
          cnt_next[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      btn_state <= '1;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= state_next[i];
        cnt[i]   <= cnt_next[i];
      end
      btn_state <= (btn_state & ~accept) | (s & accept);
    end
  end

  // An accepted change away from released is a press.
  assign press = accept & btn_state;

  logic             wr;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] mask_lo;
  logic [WIDTH-1:0] mask_hi;
  logic [WIDTH-1:0] long_cap;

  assign wr       = chipselect & ~write_n;
  assign edge_clr = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
      mask_lo  <= '0;
    end else begin
      edge_cap <= (edge_cap & ~edge_clr) | press;
      if (wr && address == 2'd1) mask_lo <= writedata[WIDTH-1:0];
    end
  end

`ifdef BUTTON_PIO_LONGPRESS_EN
  localparam logic [23:0] LONG_LIM = 24'(LONG_CYCLES);

  logic [23:0]      hold [WIDTH];
  logic [WIDTH-1:0] long_set;
  logic [WIDTH-1:0] long_clr;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      long_set[i] = !btn_state[i] && (hold[i] == LONG_LIM - 24'd1);
    end
  end

  assign long_clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // Saturating hold counter makes long_cap fire exactly once per press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) hold[i] <= '0;
      long_cap <= '0;
      mask_hi  <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (btn_state[i])           hold[i] <= '0;
        else if (hold[i] != LONG_LIM) hold[i] <= hold[i] + 24'd1;
      end
      long_cap <= (long_cap & ~long_clr) | long_set;
      if (wr && address == 2'd1) mask_hi <= writedata[WIDTH+7:8];
    end
  end
`else
  assign long_cap = '0;
  assign mask_hi  = '0;
`endif

  logic [31:0] rd_next;

  always_comb begin
    rd_next = '0;
    case (address)
      2'd0: rd_next[WIDTH-1:0] = btn_state;
      2'd1: begin
        rd_next[WIDTH-1:0] = mask_lo;
        rd_next[WIDTH+7:8] = mask_hi;
      end
      2'd2: rd_next[WIDTH-1:0] = edge_cap;
      2'd3: rd_next[WIDTH-1:0] = long_cap;
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_next;
      irq      <= (|(edge_cap & mask_lo)) | (|(long_cap & mask_hi));
    end
  end

endmodule

// File: tb/tb_button_pio_event_ctrl.sv
// Directed bench for button_pio_event_ctrl: debounce timing, glitch rejection, W1C, irq, long press.
// Expectations for address 3 and the long-press mask follow BUTTON_PIO_LONGPRESS_EN.
module tb_button_pio_event_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  in_port;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [2:0]  btn_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rd;

`ifdef BUTTON_PIO_LONGPRESS_EN
  localparam logic [31:0] EXP_MASK_RD = 32'h400;
  localparam logic [31:0] EXP_LONG    = 32'h4;
  localparam logic [31:0] EXP_LIRQ    = 32'h1;
`else
  localparam logic [31:0] EXP_MASK_RD = 32'h0;
  localparam logic [31:0] EXP_LONG    = 32'h0;
  localparam logic [31:0] EXP_LIRQ    = 32'h0;
`endif

  button_pio_event_ctrl #(
    .WIDTH(3), .CNT_W(16), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq), .btn_state(btn_state)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(posedge clk);
    #1 d = readdata;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; in_port = 3'b111; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset readdata", readdata, 32'h0);
    check_output("reset irq", {31'b0, irq}, 32'h0);
    check_output("reset btn_state", {29'b0, btn_state}, 32'h7);
    @(negedge clk) reset_n = 1'b1;
    bus_read(2'd0, rd);
    check_output("read addr0 after reset", rd, 32'h7);

    // btn0 low for 10 clks: btn_state[0] falls on the 6th edge
    @(negedge clk) in_port[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 check_output("btn0 still released at 5 clks", {29'b0, btn_state}, 32'h7);
    @(posedge clk);
    #1 check_output("btn0 pressed at 6 clks", {29'b0, btn_state}, 32'h6);
    repeat (4) @(posedge clk);
    @(negedge clk) in_port[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1 check_output("btn0 released again", {29'b0, btn_state}, 32'h7);
    bus_read(2'd2, rd);
    check_output("edge_cap after btn0", rd, 32'h1);
    check_output("irq masked off", {31'b0, irq}, 32'h0);

    // 3-clk glitch on btn1 must be rejected
    @(negedge clk) in_port[1] = 1'b0;
    repeat (3) @(negedge clk);
    in_port[1] = 1'b1;
    repeat (10) @(posedge clk);
    #1 check_output("glitch btn_state", {29'b0, btn_state}, 32'h7);
    bus_read(2'd2, rd);
    check_output("glitch edge_cap", rd, 32'h1);

    bus_write(2'd2, 32'h1);
    bus_read(2'd2, rd);
    check_output("edge_cap cleared", rd, 32'h0);
    bus_write(2'd1, 32'h1);
    bus_read(2'd1, rd);
    check_output("mask readback", rd, 32'h1);
    check_output("irq idle with mask", {31'b0, irq}, 32'h0);

    // masked press raises irq one clk after capture
    @(negedge clk) in_port[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1 check_output("irq not yet at capture edge", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1 check_output("irq raised", {31'b0, irq}, 32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk) in_port[0] = 1'b1;
    repeat (10) @(posedge clk);

    // W1C: readdata shows pre-clear value, irq drops one clk later
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h1;
    @(posedge clk);
    #1 check_output("addr2 read before clear", readdata, 32'h1);
    check_output("irq still high on clear edge", {31'b0, irq}, 32'h1);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    @(posedge clk);
    #1 check_output("irq fell after clear", {31'b0, irq}, 32'h0);

    // press capture coincides with W1C of the same bit: set wins
    @(negedge clk) in_port[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h1;
    @(posedge clk);
    #1 check_output("btn0 captured on clear edge", {29'b0, btn_state}, 32'h6);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    bus_read(2'd2, rd);
    check_output("set wins over clear", rd, 32'h1);
    check_output("irq after set-wins", {31'b0, irq}, 32'h1);
    @(negedge clk) in_port[0] = 1'b1;
    repeat (10) @(posedge clk);

    // long press on btn2 with only the long-press mask bit set
    bus_write(2'd2, 32'h7);
    bus_write(2'd1, 32'h400);
    bus_read(2'd1, rd);
    check_output("long mask readback", rd, EXP_MASK_RD);
    check_output("irq before long press", {31'b0, irq}, 32'h0);
    @(negedge clk) in_port[2] = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk) in_port[2] = 1'b1;
    check_output("long irq", {31'b0, irq}, EXP_LIRQ);
    bus_read(2'd3, rd);
    check_output("long_cap", rd, EXP_LONG);
    bus_read(2'd2, rd);
    check_output("edge_cap btn2", rd, 32'h4);
    repeat (10) @(posedge clk);
    bus_write(2'd3, 32'h4);
    @(posedge clk);
    #1 check_output("irq after long clear", {31'b0, irq}, 32'h0);
    bus_read(2'd3, rd);
    check_output("long_cap cleared", rd, 32'h0);

    // mid-operation async reset with irq high
    bus_write(2'd1, 32'h4);
    @(posedge clk);
    #1 check_output("irq before reset", {31'b0, irq}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check_output("reset irq mid-run", {31'b0, irq}, 32'h0);
    check_output("reset readdata mid-run", readdata, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    bus_read(2'd2, rd);
    check_output("edge_cap after reset", rd, 32'h0);
    bus_read(2'd1, rd);
    check_output("mask after reset", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
